// File: rtl/load_store_unit.sv
// load_store_unit: data-memory access stage with a request/acknowledge port, byte lanes and an ack timeout.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_st,
    input  logic        start_ld,
    input  logic        stype,
    input  logic        ltype,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err_misalign,
    output logic        err_timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERR} state_t;
    state_t      state, state_n;
    logic        op_st, is_byte, start, word;
    logic [1:0]  lane;
    logic [7:0]  cnt, lbu_byte;
    always_comb begin
        start    = start_st | start_ld;
        word     = start_st ? ~stype : ~ltype;
        lbu_byte = 8'(mem_rdata >> {lane, 3'b000});
        state_n  = state;
        case (state)
            IDLE:    state_n = start ? ((word && addr[1:0] != 2'b00) ? ERR : ACCESS) : IDLE;
            ACCESS:  state_n = mem_ack ? DONE : (cnt == 8'(TIMEOUT - 1) ? ERR : ACCESS);
            default: state_n = IDLE;
        endcase
    end
    assign busy    = state != IDLE;
    assign done    = state == DONE || state == ERR;
    assign mem_req = state == ACCESS;
    assign mem_be  = mem_req ? ((op_st && is_byte) ? 4'b0001 << lane : 4'b1111) : 4'b0000;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            op_st        <= 1'b0;
            is_byte      <= 1'b0;
            lane         <= 2'b00;
            cnt          <= 8'd0;
            rdata        <= 32'd0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= 32'd0;
            mem_wdata    <= 32'd0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) begin
                op_st        <= start_st;
                is_byte      <= start_st ? stype : ltype;
                lane         <= addr[1:0];
                cnt          <= 8'd0;
                err_misalign <= state_n == ERR;
                err_timeout  <= 1'b0;
                // memory-side outputs only move when a request will actually be issued
                if (state_n == ACCESS) begin
                    mem_addr <= {addr[31:2], 2'b00};
                    mem_we   <= start_st;
                    if (start_st)
                        mem_wdata <= stype ? {4{wdata[7:0]}} : wdata;
                end
            end
            if (state == ACCESS) begin
                cnt <= cnt + 8'd1;
                if (mem_ack && !op_st)
                    rdata <= is_byte ? {24'd0, lbu_byte} : mem_rdata;
                if (state_n == ERR)
                    err_timeout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a default instance and a TIMEOUT=4 instance.
module tb_load_store_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        start_st = 1'b0, start_ld = 1'b0, stype = 1'b0, ltype = 1'b0, mem_ack = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0, mem_rdata = 32'd0;
    logic        busy, done, err_misalign, err_timeout, mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic        t_busy, t_done, t_err_misalign, t_err_timeout, t_mem_req, t_mem_we;
    logic [3:0]  t_mem_be;
    logic [31:0] t_rdata, t_mem_addr, t_mem_wdata;
    int          checks = 0, errors = 0, reqs;

    load_store_unit dut (
        .clk(clk), .rst(rst), .start_st(start_st), .start_ld(start_ld), .stype(stype), .ltype(ltype),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata), .err_misalign(err_misalign),
        .err_timeout(err_timeout), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.TIMEOUT(4)) dut_t4 (
        .clk(clk), .rst(rst), .start_st(start_st), .start_ld(start_ld), .stype(stype), .ltype(ltype),
        .addr(addr), .wdata(wdata), .busy(t_busy), .done(t_done), .rdata(t_rdata), .err_misalign(t_err_misalign),
        .err_timeout(t_err_timeout), .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_be(t_mem_be), .mem_addr(t_mem_addr),
        .mem_wdata(t_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic go(input logic st, input logic sz, input logic [31:0] a, input logic [31:0] d);
        start_st = st;
        start_ld = ~st;
        stype    = sz;
        ltype    = sz;
        addr     = a;
        wdata    = d;
        tick();
        start_st = 1'b0;
        start_ld = 1'b0;
    endtask

    task automatic ack(input logic [31:0] d);
        mem_ack   = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack   = 1'b0;
    endtask

    initial begin
        start_st = 1'b1;
        repeat (3) tick();
        chk("rst_busy", busy, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_be", mem_be, 0);
        rst = 1'b1;
        start_st = 1'b0;
        tick();

        go(1, 0, 32'h104, 32'hDEADBEEF);
        chk("sw_req", mem_req, 1);
        chk("sw_addr", mem_addr, 32'h104);
        chk("sw_be", mem_be, 4'b1111);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        chk("sw_we", mem_we, 1);
        ack(32'h0);
        chk("sw_done", done, 1);
        chk("sw_rdata", rdata, 0);
        chk("sw_req_off", mem_req, 0);
        tick();
        chk("sw_idle", busy, 0);

        go(1, 1, 32'h207, 32'h000000A5);
        chk("sb_addr", mem_addr, 32'h204);
        chk("sb_be", mem_be, 4'b1000);
        chk("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        ack(32'h0);
        chk("sb_done", done, 1);
        tick();

        go(0, 1, 32'h206, 32'h0);
        chk("lbu_we", mem_we, 0);
        chk("lbu_be", mem_be, 4'b1111);
        chk("lbu_addr", mem_addr, 32'h204);
        ack(32'h11C32244);
        chk("lbu_rdata", rdata, 32'h000000C3);
        tick();

        go(0, 0, 32'h10, 32'h0);
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req) reqs++;
            tick();
        end
        if (mem_req) reqs++;
        ack(32'h12345678);
        chk("lw_done", done, 1);
        chk("lw_rdata", rdata, 32'h12345678);
        tick();
        chk("lw_req_cycles", reqs, 6);
        chk("lw_done_once", done, 0);
        chk("lw_busy_off", busy, 0);

        go(0, 0, 32'h12, 32'h0);
        chk("mis_done", done, 1);
        chk("mis_flag", err_misalign, 1);
        chk("mis_req", mem_req, 0);
        chk("mis_addr_held", mem_addr, 32'h10);
        go(0, 0, 32'h20, 32'h0);
        chk("busy_start_ignored", busy, 0);
        chk("mis_flag_held", err_misalign, 1);
        go(0, 0, 32'h20, 32'h0);
        chk("mis_cleared", err_misalign, 0);
        chk("aligned_req", mem_req, 1);
        ack(32'h0);
        tick();

        go(0, 0, 32'h30, 32'h0);
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            if (t_mem_req) reqs++;
            tick();
        end
        chk("to_req_cycles", reqs, 4);
        chk("to_done", t_done, 1);
        chk("to_flag", t_err_timeout, 1);
        chk("to_req_off", t_mem_req, 0);
        chk("to_be_off", t_mem_be, 0);
        ack(32'h0);
        tick();

        go(0, 0, 32'h34, 32'h0);
        repeat (3) tick();
        chk("to_edge_req", t_mem_req, 1);
        ack(32'hCAFEF00D);
        chk("to_edge_done", t_done, 1);
        chk("to_edge_flag", t_err_timeout, 0);
        chk("to_edge_rdata", t_rdata, 32'hCAFEF00D);
        tick();

        go(1, 0, 32'h40, 32'h55AA55AA);
        chk("mid_req", mem_req, 1);
        rst = 1'b0;
        tick();
        chk("mid_req_off", mem_req, 0);
        chk("mid_busy", busy, 0);
        chk("mid_rdata", rdata, 0);
        rst = 1'b1;
        ack(32'hFFFFFFFF);
        chk("late_ack_done", done, 0);
        chk("late_ack_busy", busy, 0);
        chk("late_ack_rdata", rdata, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
